icache_ctrl: RTL and testbench

- Controller on the other side of the 32-line instruction cache memory.
- Takes three fetch PCs and drives their lookups (index and tag) into the cache memory. Returns hit words to fetch.
- On a miss, allocates a miss-status entry, issues a BUS_LOAD to memory, matches the tagged memory response, and drives the single cache write port (wrEN, index, tag, data) to fill the line.
- Sits between the fetch stage, the icache memory and the memory bus arbiter.

---
 rtl/sys_defs.sv | 33 +++
 rtl/icache_mshr.sv | 190 +++++++++++++++++++
 rtl/icache_ctrl.sv | 75 +++++++
 tb/tb_icache_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared types and constants for the instruction-cache controller and its MSHR file.
package sys_defs;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        FREE = 2'h0,
        PEND = 2'h1,
        WAIT = 2'h2
    } ICACHE_MSHR_STATE;

    localparam int ICACHE_IDX_BITS = 5;
    localparam int ICACHE_TAG_BITS = 8;
    localparam int ICACHE_BLK_BITS = ICACHE_IDX_BITS + ICACHE_TAG_BITS;
    localparam int MEM_TAG_BITS    = 4;

    typedef struct packed {
        ICACHE_MSHR_STATE            state;
        logic [ICACHE_IDX_BITS-1:0]  index;
        logic [ICACHE_TAG_BITS-1:0]  tag;
        logic [MEM_TAG_BITS-1:0]     mem_tag;
    } ICACHE_MSHR_ENTRY;

    // Block number of an entry: {tag, index}, i.e. PC[15:3].
    function automatic logic [ICACHE_BLK_BITS-1:0] mshr_blk(input ICACHE_MSHR_ENTRY e);
        return {e.tag, e.index};
    endfunction

endpackage

// File: rtl/icache_mshr.sv
// Miss-status entries: allocation, in-order bus issue, memory tag match for fills.
// Defining ICACHE_PREFETCH_EN adds a next-block allocation alongside each demand miss.
module icache_mshr
    import sys_defs::*;
#(
    parameter int NUM_MSHR  = 4,
    parameter int NUM_PORTS = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_PORTS-1:0]                      miss_req,
    input  logic [NUM_PORTS-1:0][ICACHE_IDX_BITS-1:0] miss_index,
    input  logic [NUM_PORTS-1:0][ICACHE_TAG_BITS-1:0] miss_tag,
    input  logic [MEM_TAG_BITS-1:0]                   mem_response,
    input  logic [MEM_TAG_BITS-1:0]                   mem_tag,
    output logic                                      issue_valid,
    output logic [ICACHE_IDX_BITS-1:0]                issue_index,
    output logic [ICACHE_TAG_BITS-1:0]                issue_tag,
    output logic                                      fill_en,
    output logic [ICACHE_IDX_BITS-1:0]                fill_index,
    output logic [ICACHE_TAG_BITS-1:0]                fill_tag
);
    localparam int PTR_W = $clog2(NUM_MSHR);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [ICACHE_BLK_BITS-1:0] blk_t;

    ICACHE_MSHR_ENTRY  mshr_q [NUM_MSHR];
    // Circular list of PEND entries in allocation order; rd_ptr_q is the order counter.
    logic [PTR_W-1:0]  order_q [NUM_MSHR];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  pend_cnt_q;

    logic [PTR_W-1:0]  fill_id;
    logic [PTR_W-1:0]  issue_id;
    logic [PTR_W-1:0]  free0_id;
    logic              free0_found;
    logic              cand_found;
    logic              port_dup;
    logic              alloc0;
    logic              accept;
    logic              wait_tag_dup;
    logic [CNT_W-1:0]  fill_match_cnt;
    logic [1:0]        alloc_n;
    blk_t              cand_blk;
    blk_t              port_blk;
`ifdef ICACHE_PREFETCH_EN
    logic [PTR_W-1:0]  free1_id;
    logic              free1_found;
    logic              pf_dup;
    logic              alloc1;
    blk_t              pf_blk;
`endif

    always_comb begin
        fill_en        = 1'b0;
        fill_id        = '0;
        fill_match_cnt = '0;
        for (int e = 0; e < NUM_MSHR; e++) begin
            if (mem_tag != '0 && mshr_q[e].state == WAIT && mshr_q[e].mem_tag == mem_tag) begin
                if (!fill_en) fill_id = PTR_W'(e);
                fill_en        = 1'b1;
                fill_match_cnt = fill_match_cnt + CNT_W'(1);
            end
        end
        fill_index = fill_en ? mshr_q[fill_id].index : '0;
        fill_tag   = fill_en ? mshr_q[fill_id].tag   : '0;
    end

    always_comb begin
        wait_tag_dup = 1'b0;
        for (int a = 0; a < NUM_MSHR; a++) begin
            for (int b = a + 1; b < NUM_MSHR; b++) begin
                if (mshr_q[a].state == WAIT && mshr_q[b].state == WAIT &&
                    mshr_q[a].mem_tag == mshr_q[b].mem_tag)
                    wait_tag_dup = 1'b1;
            end
        end
    end

    always_comb begin
        free0_found = 1'b0;
        free0_id    = '0;
`ifdef ICACHE_PREFETCH_EN
        free1_found = 1'b0;
        free1_id    = '0;
`endif
        for (int e = 0; e < NUM_MSHR; e++) begin
            if (mshr_q[e].state == FREE) begin
`ifdef ICACHE_PREFETCH_EN
                if (free0_found && !free1_found) begin
                    free1_found = 1'b1;
                    free1_id    = PTR_W'(e);
                end
`endif
                if (!free0_found) begin
                    free0_found = 1'b1;
                    free0_id    = PTR_W'(e);
                end
            end
        end
    end

    // A block being filled is still WAIT here, so the busy check also covers it.
    always_comb begin
        cand_found = 1'b0;
        cand_blk   = '0;
        port_blk   = '0;
        port_dup   = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_blk = {miss_tag[p], miss_index[p]};
            port_dup = 1'b0;
            for (int e = 0; e < NUM_MSHR; e++) begin
                if (mshr_q[e].state != FREE && mshr_blk(mshr_q[e]) == port_blk)
                    port_dup = 1'b1;
            end
            if (miss_req[p] && !port_dup && !cand_found) begin
                cand_found = 1'b1;
                cand_blk   = port_blk;
            end
        end
        alloc0 = cand_found && free0_found;
`ifdef ICACHE_PREFETCH_EN
        pf_blk = cand_blk + blk_t'(1);
        pf_dup = 1'b0;
        for (int e = 0; e < NUM_MSHR; e++) begin
            if (mshr_q[e].state != FREE && mshr_blk(mshr_q[e]) == pf_blk)
                pf_dup = 1'b1;
        end
        alloc1  = alloc0 && free1_found && !pf_dup;
        alloc_n = {1'b0, alloc0} + {1'b0, alloc1};
`else
        alloc_n = {1'b0, alloc0};
`endif
    end

    always_comb begin
        issue_valid = (pend_cnt_q != '0);
        issue_id    = order_q[rd_ptr_q];
        issue_index = issue_valid ? mshr_q[issue_id].index : '0;
        issue_tag   = issue_valid ? mshr_q[issue_id].tag   : '0;
        accept      = issue_valid && (mem_response != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < NUM_MSHR; e++) begin
                mshr_q[e]  <= '0;
                order_q[e] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            pend_cnt_q <= '0;
        end else begin
            if (fill_en) mshr_q[fill_id].state <= FREE;
            if (accept) begin
                mshr_q[issue_id].state   <= WAIT;
                mshr_q[issue_id].mem_tag <= mem_response;
            end
            if (alloc0) begin
                mshr_q[free0_id] <= '{state:   PEND,
                                      index:   cand_blk[ICACHE_IDX_BITS-1:0],
                                      tag:     cand_blk[ICACHE_BLK_BITS-1:ICACHE_IDX_BITS],
                                      mem_tag: '0};
                order_q[wr_ptr_q] <= free0_id;
            end
`ifdef ICACHE_PREFETCH_EN
            if (alloc1) begin
                mshr_q[free1_id] <= '{state:   PEND,
                                      index:   pf_blk[ICACHE_IDX_BITS-1:0],
                                      tag:     pf_blk[ICACHE_BLK_BITS-1:ICACHE_IDX_BITS],
                                      mem_tag: '0};
                order_q[wr_ptr_q + PTR_W'(1)] <= free1_id;
            end
`endif
            wr_ptr_q   <= wr_ptr_q + PTR_W'(alloc_n);
            rd_ptr_q   <= rd_ptr_q + PTR_W'(accept);
            pend_cnt_q <= pend_cnt_q + CNT_W'(alloc_n) - CNT_W'(accept);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fill_match_cnt <= CNT_W'(1));
            assert (!wait_tag_dup);
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// Instruction-cache controller: combinational lookup/word select, misses handled by icache_mshr.
// Define ICACHE_PREFETCH_EN to also request the next sequential block on each demand miss.
module icache_ctrl
    import sys_defs::*;
#(
    parameter int NUM_MSHR  = 4,
    parameter int NUM_PORTS = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_PORTS-1:0][31:0]                proc2Icache_addr,
    input  logic [NUM_PORTS-1:0]                      proc2Icache_en,
    input  logic [NUM_PORTS-1:0][63:0]                cachemem_data,
    input  logic [NUM_PORTS-1:0]                      cachemem_valid,
    output logic [NUM_PORTS-1:0][ICACHE_IDX_BITS-1:0] Icache_rd_index,
    output logic [NUM_PORTS-1:0][ICACHE_TAG_BITS-1:0] Icache_rd_tag,
    output logic                                      Icache_wrEN,
    output logic [ICACHE_IDX_BITS-1:0]                Icache_wr_index,
    output logic [ICACHE_TAG_BITS-1:0]                Icache_wr_tag,
    output logic [63:0]                               Icache_wr_data,
    output logic [NUM_PORTS-1:0][31:0]                Icache_data_out,
    output logic [NUM_PORTS-1:0]                      Icache_valid_out,
    output BUS_COMMAND                                proc2mem_command,
    output logic [31:0]                               proc2mem_addr,
    input  logic [3:0]                                mem2proc_response,
    input  logic [63:0]                               mem2proc_data,
    input  logic [3:0]                                mem2proc_tag
);
    logic [NUM_PORTS-1:0]       miss_req;
    logic                       issue_valid;
    logic [ICACHE_IDX_BITS-1:0] issue_index;
    logic [ICACHE_TAG_BITS-1:0] issue_tag;
    logic                       unused_pc_bits;

    always_comb begin
        Icache_rd_index = '0;
        Icache_rd_tag   = '0;
        Icache_data_out = '0;
        unused_pc_bits  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            Icache_rd_index[i] = proc2Icache_addr[i][7:3];
            Icache_rd_tag[i]   = proc2Icache_addr[i][15:8];
            Icache_data_out[i] = proc2Icache_addr[i][2] ? cachemem_data[i][63:32]
                                                       : cachemem_data[i][31:0];
            unused_pc_bits     = unused_pc_bits ^ (^{proc2Icache_addr[i][31:16],
                                                     proc2Icache_addr[i][1:0]});
        end
        Icache_valid_out = proc2Icache_en & cachemem_valid;
        miss_req         = proc2Icache_en & ~cachemem_valid;
    end

    icache_mshr #(
        .NUM_MSHR  (NUM_MSHR),
        .NUM_PORTS (NUM_PORTS)
    ) u_mshr (
        .clk          (clk),
        .rst          (rst),
        .miss_req     (miss_req),
        .miss_index   (Icache_rd_index),
        .miss_tag     (Icache_rd_tag),
        .mem_response (mem2proc_response),
        .mem_tag      (mem2proc_tag),
        .issue_valid  (issue_valid),
        .issue_index  (issue_index),
        .issue_tag    (issue_tag),
        .fill_en      (Icache_wrEN),
        .fill_index   (Icache_wr_index),
        .fill_tag     (Icache_wr_tag)
    );

    assign Icache_wr_data   = Icache_wrEN ? mem2proc_data : '0;
    assign proc2mem_command = issue_valid ? BUS_LOAD : BUS_NONE;
    assign proc2mem_addr    = {16'b0, issue_tag, issue_index, 3'b0};

endmodule

// File: tb/tb_icache_ctrl.sv
// Scenario bench for icache_ctrl: expected bus requests and fills go through queues.
module tb_icache_ctrl;
    import sys_defs::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0][31:0] proc2Icache_addr;
    logic [2:0]       proc2Icache_en;
    logic [2:0][63:0] cachemem_data;
    logic [2:0]       cachemem_valid;
    logic [2:0][4:0]  Icache_rd_index;
    logic [2:0][7:0]  Icache_rd_tag;
    logic             Icache_wrEN;
    logic [4:0]       Icache_wr_index;
    logic [7:0]       Icache_wr_tag;
    logic [63:0]      Icache_wr_data;
    logic [2:0][31:0] Icache_data_out;
    logic [2:0]       Icache_valid_out;
    BUS_COMMAND       proc2mem_command;
    logic [31:0]      proc2mem_addr;
    logic [3:0]       mem2proc_response;
    logic [63:0]      mem2proc_data;
    logic [3:0]       mem2proc_tag;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk(clk), .rst(rst),
        .proc2Icache_addr(proc2Icache_addr), .proc2Icache_en(proc2Icache_en),
        .cachemem_data(cachemem_data), .cachemem_valid(cachemem_valid),
        .Icache_rd_index(Icache_rd_index), .Icache_rd_tag(Icache_rd_tag),
        .Icache_wrEN(Icache_wrEN), .Icache_wr_index(Icache_wr_index),
        .Icache_wr_tag(Icache_wr_tag), .Icache_wr_data(Icache_wr_data),
        .Icache_data_out(Icache_data_out), .Icache_valid_out(Icache_valid_out),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] iss_q [$];   // expected BUS_LOAD addresses, oldest first
    logic [76:0] fill_q [$];  // expected {wr_index, wr_tag, wr_data}

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        proc2Icache_addr  = '0;
        proc2Icache_en    = '0;
        cachemem_data     = '0;
        cachemem_valid    = '0;
        mem2proc_response = '0;
        mem2proc_data     = '0;
        mem2proc_tag      = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        proc2Icache_en      = 3'b001;
        proc2Icache_addr[0] = 32'h700;
        mem2proc_tag        = 4'd3;
        tick();
        tick();
        total++;
        if (proc2mem_command !== BUS_NONE || proc2mem_addr !== 32'h0 || Icache_wrEN !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: cmd=%0d addr=%h wrEN=%b, want cmd=0 addr=0 wrEN=0",
                     proc2mem_command, proc2mem_addr, Icache_wrEN);
        end
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_hit();
        idle();
        proc2Icache_en      = 3'b011;
        cachemem_valid      = 3'b011;
        proc2Icache_addr[0] = 32'h100;
        proc2Icache_addr[1] = 32'h104;
        cachemem_data[0]    = 64'hAAAA_BBBB_CCCC_DDDD;
        cachemem_data[1]    = 64'h1111_2222_3333_4444;
        #1;
        total++;
        if (Icache_valid_out !== 3'b011 || Icache_data_out[0] !== 32'hCCCC_DDDD) begin
            bad++;
            $display("FAIL hit_low_word: valid=%b data0=%h, want valid=011 data0=ccccdddd",
                     Icache_valid_out, Icache_data_out[0]);
        end
        total++;
        if (Icache_data_out[1] !== 32'h1111_2222) begin
            bad++;
            $display("FAIL hit_high_word: data1=%h want 11112222", Icache_data_out[1]);
        end
        total++;
        if (Icache_rd_index[0] !== 5'd0 || Icache_rd_tag[0] !== 8'h01 || Icache_rd_index[1] !== 5'd0) begin
            bad++;
            $display("FAIL hit_split: idx0=%h tag0=%h idx1=%h, want 0 01 0",
                     Icache_rd_index[0], Icache_rd_tag[0], Icache_rd_index[1]);
        end
        tick();
        total++;
        if (proc2mem_command !== BUS_NONE) begin
            bad++;
            $display("FAIL hit_no_load: cmd=%0d want BUS_NONE", proc2mem_command);
        end
        idle();
        tick();
    endtask

    task automatic test_miss_fill();
        logic [63:0] x;
        x = 64'h0123_4567_89AB_CDEF;
        idle();
        proc2Icache_en      = 3'b001;
        proc2Icache_addr[0] = 32'h108;
        iss_q.push_back(32'h108);
        #1;
        total++;
        if (proc2mem_command !== BUS_NONE) begin
            bad++;
            $display("FAIL miss_alloc_cycle: cmd=%0d want BUS_NONE", proc2mem_command);
        end
        tick();
        mem2proc_response = 4'd3;
        #1;
        total++;
        if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== iss_q[0]) begin
            bad++;
            $display("FAIL miss_issue: cmd=%0d addr=%h, want BUS_LOAD addr=%h",
                     proc2mem_command, proc2mem_addr, iss_q[0]);
        end
        void'(iss_q.pop_front());
        tick();
        mem2proc_response = 4'd0;
        #1;
        total++;
        if (proc2mem_command !== BUS_NONE) begin
            bad++;
            $display("FAIL miss_wait_quiet: cmd=%0d want BUS_NONE", proc2mem_command);
        end
        tick();
        mem2proc_tag  = 4'd3;
        mem2proc_data = x;
        fill_q.push_back({5'd1, 8'h01, x});
        #1;
        total++;
        if (Icache_wrEN !== 1'b1 || {Icache_wr_index, Icache_wr_tag, Icache_wr_data} !== fill_q[0]) begin
            bad++;
            $display("FAIL miss_fill: wrEN=%b got=%h want=%h", Icache_wrEN,
                     {Icache_wr_index, Icache_wr_tag, Icache_wr_data}, fill_q[0]);
        end
        void'(fill_q.pop_front());
        tick();
        idle();
        #1;
        total++;
        if (Icache_wrEN !== 1'b0 || proc2mem_command !== BUS_NONE) begin
            bad++;
            $display("FAIL miss_after_fill: wrEN=%b cmd=%0d, want 0 BUS_NONE", Icache_wrEN, proc2mem_command);
        end
        tick();
    endtask

    task automatic test_reissue();
        logic [63:0] d;
        d = 64'hFEED_0000_BEEF_1111;
        idle();
        proc2Icache_en      = 3'b001;
        proc2Icache_addr[0] = 32'h300;
        iss_q.push_back(32'h300);
        tick();
        for (int k = 0; k < 3; k++) begin
            mem2proc_response = (k == 2) ? 4'd5 : 4'd0;
            #1;
            total++;
            if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== iss_q[0]) begin
                bad++;
                $display("FAIL reissue_%0d: cmd=%0d addr=%h, want BUS_LOAD addr=%h",
                         k, proc2mem_command, proc2mem_addr, iss_q[0]);
            end
            tick();
        end
        void'(iss_q.pop_front());
        idle();
        #1;
        total++;
        if (proc2mem_command !== BUS_NONE) begin
            bad++;
            $display("FAIL reissue_wait: cmd=%0d want BUS_NONE", proc2mem_command);
        end
        tick();
        mem2proc_tag  = 4'd5;
        mem2proc_data = d;
        fill_q.push_back({5'd0, 8'h03, d});
        #1;
        total++;
        if (Icache_wrEN !== 1'b1 || {Icache_wr_index, Icache_wr_tag, Icache_wr_data} !== fill_q[0]) begin
            bad++;
            $display("FAIL reissue_fill: wrEN=%b got=%h want=%h", Icache_wrEN,
                     {Icache_wr_index, Icache_wr_tag, Icache_wr_data}, fill_q[0]);
        end
        void'(fill_q.pop_front());
        tick();
        idle();
        tick();
    endtask

    task automatic test_dup();
        logic [63:0] d;
        d = 64'h2222_3333_4444_5555;
        idle();
        proc2Icache_en      = 3'b101;
        proc2Icache_addr[0] = 32'h200;
        proc2Icache_addr[2] = 32'h200;
        iss_q.push_back(32'h200);
        tick();
        mem2proc_response = 4'd6;
        #1;
        total++;
        if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== iss_q[0]) begin
            bad++;
            $display("FAIL dup_issue: cmd=%0d addr=%h, want BUS_LOAD addr=%h",
                     proc2mem_command, proc2mem_addr, iss_q[0]);
        end
        void'(iss_q.pop_front());
        tick();
        mem2proc_response = 4'd0;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++;
            if (proc2mem_command !== BUS_NONE) begin
                bad++;
                $display("FAIL dup_single_%0d: cmd=%0d addr=%h want BUS_NONE", k, proc2mem_command, proc2mem_addr);
            end
            tick();
        end
        idle();
        mem2proc_tag  = 4'd6;
        mem2proc_data = d;
        fill_q.push_back({5'd0, 8'h02, d});
        #1;
        total++;
        if (Icache_wrEN !== 1'b1 || {Icache_wr_index, Icache_wr_tag, Icache_wr_data} !== fill_q[0]) begin
            bad++;
            $display("FAIL dup_fill: wrEN=%b got=%h want=%h", Icache_wrEN,
                     {Icache_wr_index, Icache_wr_tag, Icache_wr_data}, fill_q[0]);
        end
        void'(fill_q.pop_front());
        tick();
        idle();
        tick();
    endtask

    task automatic test_full();
        logic [3:0]  tags [4];
        logic [4:0]  idxs [4];
        logic [63:0] d;
        tags = '{4'd1, 4'd3, 4'd4, 4'd7};
        idxs = '{5'd0, 5'd2, 5'd3, 5'd4};
        idle();
        proc2Icache_en = 3'b001;
        for (int k = 0; k < 5; k++) begin
            proc2Icache_addr[0] = 32'h400 + 32'(8 * k);
            if (k < 4) iss_q.push_back(proc2Icache_addr[0]);
            mem2proc_response = 4'(k);
            #1;
            if (k > 0) begin
                total++;
                if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== iss_q[0]) begin
                    bad++;
                    $display("FAIL full_issue_%0d: cmd=%0d addr=%h, want BUS_LOAD addr=%h",
                             k, proc2mem_command, proc2mem_addr, iss_q[0]);
                end
                void'(iss_q.pop_front());
            end
            tick();
        end
        mem2proc_response = 4'd0;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++;
            if (proc2mem_command !== BUS_NONE) begin
                bad++;
                $display("FAIL full_blocked_%0d: cmd=%0d addr=%h want BUS_NONE", k, proc2mem_command, proc2mem_addr);
            end
            tick();
        end
        d = 64'h0BAD_F00D_0000_0002;
        mem2proc_tag  = 4'd2;
        mem2proc_data = d;
        fill_q.push_back({5'd1, 8'h04, d});
        #1;
        total++;
        if (Icache_wrEN !== 1'b1 || {Icache_wr_index, Icache_wr_tag, Icache_wr_data} !== fill_q[0]) begin
            bad++;
            $display("FAIL full_fill: wrEN=%b got=%h want=%h", Icache_wrEN,
                     {Icache_wr_index, Icache_wr_tag, Icache_wr_data}, fill_q[0]);
        end
        void'(fill_q.pop_front());
        tick();
        mem2proc_tag = 4'd0;
        iss_q.push_back(32'h420);
        #1;
        total++;
        if (proc2mem_command !== BUS_NONE) begin
            bad++;
            $display("FAIL full_realloc_cycle: cmd=%0d want BUS_NONE", proc2mem_command);
        end
        tick();
        mem2proc_response = 4'd7;
        #1;
        total++;
        if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== iss_q[0]) begin
            bad++;
            $display("FAIL full_fifth_issue: cmd=%0d addr=%h, want BUS_LOAD addr=%h",
                     proc2mem_command, proc2mem_addr, iss_q[0]);
        end
        void'(iss_q.pop_front());
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            d = {32'hD0D0_0000 + 32'(k), 32'h1234_0000 + 32'(k)};
            mem2proc_tag  = tags[k];
            mem2proc_data = d;
            fill_q.push_back({idxs[k], 8'h04, d});
            #1;
            total++;
            if (Icache_wrEN !== 1'b1 || {Icache_wr_index, Icache_wr_tag, Icache_wr_data} !== fill_q[0]) begin
                bad++;
                $display("FAIL full_drain_%0d: wrEN=%b got=%h want=%h", k, Icache_wrEN,
                         {Icache_wr_index, Icache_wr_tag, Icache_wr_data}, fill_q[0]);
            end
            void'(fill_q.pop_front());
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        proc2Icache_en      = 3'b001;
        proc2Icache_addr[0] = 32'h500;
        iss_q.push_back(32'h500);
        tick();
        proc2Icache_addr[0] = 32'h508;
        iss_q.push_back(32'h508);
        mem2proc_response   = 4'd8;
        #1;
        total++;
        if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== iss_q[0]) begin
            bad++;
            $display("FAIL rstmid_issue0: cmd=%0d addr=%h, want BUS_LOAD addr=%h",
                     proc2mem_command, proc2mem_addr, iss_q[0]);
        end
        void'(iss_q.pop_front());
        tick();
        proc2Icache_en    = 3'b000;
        mem2proc_response = 4'd9;
        #1;
        total++;
        if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== iss_q[0]) begin
            bad++;
            $display("FAIL rstmid_issue1: cmd=%0d addr=%h, want BUS_LOAD addr=%h",
                     proc2mem_command, proc2mem_addr, iss_q[0]);
        end
        void'(iss_q.pop_front());
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        iss_q.delete();
        fill_q.delete();
        total++;
        if (proc2mem_command !== BUS_NONE || proc2mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_bus_idle: cmd=%0d addr=%h want BUS_NONE 0", proc2mem_command, proc2mem_addr);
        end
        for (int k = 0; k < 2; k++) begin
            mem2proc_tag  = (k == 0) ? 4'd8 : 4'd9;
            mem2proc_data = 64'hDEAD_DEAD_DEAD_DEAD;
            #1;
            total++;
            if (Icache_wrEN !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_stale_tag_%0d: wrEN=%b want 0", k, Icache_wrEN);
            end
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss_fill();
        test_reissue();
        test_dup();
        test_full();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
